// File: rtl/seven_seg_reader.sv
// Samples a multiplexed seven-segment display bus and captures each digit's hex value
// once its pattern has been stable. Optional blank-digit support: SEVEN_SEG_READER_BLANK_EN.
module seven_seg_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        err,
    output logic [1:0]  err_digit,
    output logic [3:0]  blank
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SAMPLE_W = 11;
    localparam logic        ONE_CYCLE = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    count_q;
    logic [SAMPLE_W-1:0] prev_q;
    logic [3:0]          seen_q;
    logic [15:0]         digits_q;
    logic [3:0]          digit_valid_q;
    logic                frame_done_q;
    logic                err_q;
    logic [1:0]          err_digit_q;

    logic       dec_valid_c;
    logic       dec_blank_c;
    logic [3:0] dec_val_c;
    logic [1:0] idx_c;
    logic       onehot_c;
    logic       restart_c;
    logic       capture_c;
    logic [3:0] seen_set_c;

    // Segment pattern to hex value; all-off is only legal when blank support is built in.
    always_comb begin
        dec_valid_c = 1'b1;
        dec_blank_c = 1'b0;
        dec_val_c   = 4'h0;
        case (seg)
            7'h3F: dec_val_c = 4'h0;
            7'h06: dec_val_c = 4'h1;
            7'h5B: dec_val_c = 4'h2;
            7'h4F: dec_val_c = 4'h3;
            7'h66: dec_val_c = 4'h4;
            7'h6D: dec_val_c = 4'h5;
            7'h7D: dec_val_c = 4'h6;
            7'h07: dec_val_c = 4'h7;
            7'h7F: dec_val_c = 4'h8;
            7'h67: dec_val_c = 4'h9;
            7'h77: dec_val_c = 4'hA;
            7'h7C: dec_val_c = 4'hB;
            7'h39: dec_val_c = 4'hC;
            7'h5E: dec_val_c = 4'hD;
            7'h79: dec_val_c = 4'hE;
            7'h71: dec_val_c = 4'hF;
`ifdef SEVEN_SEG_READER_BLANK_EN
            7'h00: dec_blank_c = 1'b1;
`endif
            default: dec_valid_c = 1'b0;
        endcase
    end

    // Dwell tracking: a new or changed sample restarts the count at 1.
    always_comb begin
        idx_c = 2'd0;
        case (an)
            4'b0010: idx_c = 2'd1;
            4'b0100: idx_c = 2'd2;
            4'b1000: idx_c = 2'd3;
            default: idx_c = 2'd0;
        endcase
        onehot_c   = $onehot(an);
        restart_c  = (state_q == IDLE) || ({an, seg} != prev_q);
        capture_c  = 1'b0;
        if (onehot_c) begin
            if (restart_c) begin
                capture_c = ONE_CYCLE;
            end else if (state_q == SETTLE) begin
                capture_c = ((count_q + CNT_W'(1)) == CNT_W'(STABLE_CYCLES));
            end
        end
        seen_set_c = seen_q | (4'b0001 << idx_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            prev_q        <= '0;
            seen_q        <= '0;
            digits_q      <= '0;
            digit_valid_q <= '0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            err_digit_q   <= '0;
        end else begin
            prev_q       <= {an, seg};
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            if (!onehot_c) begin
                state_q <= IDLE;
                count_q <= '0;
            end else if (restart_c) begin
                count_q <= CNT_W'(1);
                state_q <= ONE_CYCLE ? HELD : SETTLE;
            end else if (state_q == SETTLE) begin
                count_q <= count_q + CNT_W'(1);
                if (capture_c) state_q <= HELD;
            end
            if (capture_c) begin
                if (dec_valid_c) begin
                    digits_q[{idx_c, 2'b00} +: 4] <= dec_val_c;
                    digit_valid_q[idx_c]          <= 1'b1;
                    if (seen_set_c == 4'b1111) begin
                        frame_done_q <= 1'b1;
                        seen_q       <= '0;
                    end else begin
                        seen_q <= seen_set_c;
                    end
                end else begin
                    err_q       <= 1'b1;
                    err_digit_q <= idx_c;
                end
            end
        end
    end

`ifdef SEVEN_SEG_READER_BLANK_EN
    logic [3:0] blank_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if (capture_c && dec_valid_c) begin
            blank_q[idx_c] <= dec_blank_c;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 4'b0000;
`endif

    assign digits      = digits_q;
    assign digit_valid = digit_valid_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;
    assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed self-checking bench for seven_seg_reader (STABLE_CYCLES = 4).
module tb_seven_seg_reader;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_digit;
    logic [3:0]  blank;

    int checks = 0;
    int errors = 0;

    seven_seg_reader #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err),
        .err_digit   (err_digit),
        .blank       (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample for one clock; returns at the following falling edge.
    task automatic step(input logic [3:0] a, input logic [6:0] s);
        an  = a;
        seg = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        an    = 4'b0000;
        seg   = 7'h00;
        #2;
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h exp 0000", digits); end
        checks++; if (digit_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", digit_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame got %b exp 0", frame_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (err_digit !== 2'd0) begin errors++; $display("FAIL reset_err_digit got %0d exp 0", err_digit); end
        checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL reset_blank got %b exp 0000", blank); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_capture();
        step(4'b0000, 7'h00);
        repeat (3) step(4'b0001, 7'h4F);
        checks++; if (digit_valid !== 4'b0000) begin errors++; $display("FAIL cap_early got %b exp 0000", digit_valid); end
        step(4'b0001, 7'h4F);
        checks++; if (digits[3:0] !== 4'h3) begin errors++; $display("FAIL cap_digit0 got %h exp 3", digits[3:0]); end
        checks++; if (digit_valid !== 4'b0001) begin errors++; $display("FAIL cap_valid got %b exp 0001", digit_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cap_err got %b exp 0", err); end
        step(4'b0001, 7'h4F);
        checks++; if (frame_done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL cap_held_pulses got fd=%b err=%b exp 0 0", frame_done, err); end
    endtask

    task automatic test_restart();
        repeat (3) step(4'b0010, 7'h06);
        repeat (3) step(4'b0010, 7'h5B);
        checks++; if (digit_valid !== 4'b0001) begin errors++; $display("FAIL restart_no_cap got %b exp 0001", digit_valid); end
        step(4'b0010, 7'h5B);
        checks++; if (digits[7:4] !== 4'h2) begin errors++; $display("FAIL restart_digit1 got %h exp 2", digits[7:4]); end
        checks++; if (digit_valid !== 4'b0011) begin errors++; $display("FAIL restart_valid got %b exp 0011", digit_valid); end
    endtask

    task automatic test_sweep();
        logic [3:0] ans  [4];
        logic [6:0] segs [4];
        int pulses;
        int pulse_at;
        ans[0] = 4'b0001; segs[0] = 7'h7F;
        ans[1] = 4'b0010; segs[1] = 7'h67;
        ans[2] = 4'b0100; segs[2] = 7'h77;
        ans[3] = 4'b1000; segs[3] = 7'h71;
        pulses   = 0;
        pulse_at = -1;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 6; c++) begin
                step(ans[d], segs[d]);
                if (frame_done === 1'b1) begin
                    pulses++;
                    pulse_at = d * 6 + c;
                end
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL sweep_pulses got %0d exp 1", pulses); end
        checks++; if (pulse_at !== 21) begin errors++; $display("FAIL sweep_pulse_cycle got %0d exp 21", pulse_at); end
        checks++; if (digits !== 16'hFA98) begin errors++; $display("FAIL sweep_digits got %h exp FA98", digits); end
        checks++; if (digit_valid !== 4'b1111) begin errors++; $display("FAIL sweep_valid got %b exp 1111", digit_valid); end
    endtask

    task automatic test_err();
        int errs;
        repeat (3) step(4'b0100, 7'h7E);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", err); end
        step(4'b0100, 7'h7E);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", err); end
        checks++; if (err_digit !== 2'd2) begin errors++; $display("FAIL err_digit got %0d exp 2", err_digit); end
        checks++; if (digits !== 16'hFA98) begin errors++; $display("FAIL err_digits got %h exp FA98", digits); end
        step(4'b0100, 7'h7E);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b exp 0", err); end
        errs = 0;
        repeat (6) begin
            step(4'b0110, 7'h3F);
            if (err === 1'b1) errs++;
        end
        checks++; if (errs !== 0) begin errors++; $display("FAIL multi_an_err got %0d exp 0", errs); end
        checks++; if (digits !== 16'hFA98) begin errors++; $display("FAIL multi_an_digits got %h exp FA98", digits); end
    endtask

    task automatic test_blank();
        repeat (4) step(4'b1000, 7'h00);
`ifdef SEVEN_SEG_READER_BLANK_EN
        checks++; if (blank !== 4'b1000) begin errors++; $display("FAIL blank_mask got %b exp 1000", blank); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL blank_err got %b exp 0", err); end
        checks++; if (digits !== 16'h0A98) begin errors++; $display("FAIL blank_digits got %h exp 0A98", digits); end
`else
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL blank_err got %b exp 1", err); end
        checks++; if (err_digit !== 2'd3) begin errors++; $display("FAIL blank_err_digit got %0d exp 3", err_digit); end
        checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL blank_mask got %b exp 0000", blank); end
        checks++; if (digits !== 16'hFA98) begin errors++; $display("FAIL blank_digits got %h exp FA98", digits); end
`endif
    endtask

    task automatic test_reset_mid();
        repeat (3) step(4'b0001, 7'h06);
        rst_n = 1'b0;
        #1;
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL mid_rst_digits got %h exp 0000", digits); end
        checks++; if (digit_valid !== 4'b0000) begin errors++; $display("FAIL mid_rst_valid got %b exp 0000", digit_valid); end
        checks++; if (err_digit !== 2'd0 || err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got err=%b idx=%0d exp 0 0", err, err_digit); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(4'b0001, 7'h06);
        checks++; if (digit_valid !== 4'b0000) begin errors++; $display("FAIL mid_rst_early got %b exp 0000", digit_valid); end
        step(4'b0001, 7'h06);
        checks++; if (digits !== 16'h0001) begin errors++; $display("FAIL mid_rst_digits_after got %h exp 0001", digits); end
        checks++; if (digit_valid !== 4'b0001) begin errors++; $display("FAIL mid_rst_valid_after got %b exp 0001", digit_valid); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_restart();
        test_sweep();
        test_err();
        test_blank();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
